fifo_axis_reader: RTL and testbench

Read-side adapter that drains a first-word-fall-through FIFO read port (`rd_data`/`rd_en`/`rd_empty`) and presents the words as an AXI4-Stream master with fixed-length packet framing. It sits between the team's synchronous FIFO and any downstream AXI-Stream consumer. A 2-entry skid buffer keeps full throughput while making sure `m_axis_tready` never reaches the FIFO pop combinationally. Packets are delimited by asserting `m_axis_tlast` every `PKT_LEN` beats, and completed packets are counted.

---
 rtl/fifo_axis_reader.sv | 93 +++++++++
 tb/tb_fifo_axis_reader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_axis_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_axis_reader
// Purpose  : Drains an FWFT FIFO read port onto an AXI4-Stream master with
//            fixed-length tlast framing and a completed-packet counter.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_axis_reader #(
    parameter int DWIDTH  = 32,
    parameter int PKT_LEN = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DWIDTH-1:0] fifo_rd_data,
    input  logic              fifo_rd_empty,
    output logic              fifo_rd_en,
    output logic [DWIDTH-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [31:0]       pkt_count
);

    localparam int                  c_BEAT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(PKT_LEN - 1);

    logic                r_out_valid;
    logic [DWIDTH-1:0]   r_out_data;
    logic                r_out_last;
    logic                r_skid_valid;
    logic [DWIDTH-1:0]   r_skid_data;
    logic                r_skid_last;
    logic [c_BEAT_W-1:0] r_beat;
    logic [31:0]         r_pkt_count;

    logic w_pop;
    logic w_take;
    logic w_pop_last;

    // The pop depends only on registered state, so tready never reaches the FIFO.
    assign fifo_rd_en = rst_n & ~fifo_rd_empty & ~r_skid_valid;
    assign w_pop      = fifo_rd_en;
    assign w_take     = r_out_valid & m_axis_tready;
    assign w_pop_last = (r_beat == c_LAST_BEAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_last  <= 1'b0;
            r_beat       <= '0;
            r_pkt_count  <= '0;
        end else begin
            if (w_pop) begin
                r_beat <= w_pop_last ? '0 : r_beat + c_BEAT_W'(1);
            end

            if (!r_out_valid || w_take) begin
                if (r_skid_valid) begin
                    r_out_valid  <= 1'b1;
                    r_out_data   <= r_skid_data;
                    r_out_last   <= r_skid_last;
                    r_skid_valid <= 1'b0;
                end else if (w_pop) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= fifo_rd_data;
                    r_out_last  <= w_pop_last;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_pop) begin
                // Output is stalled: park the in-flight word in the skid slot.
                r_skid_valid <= 1'b1;
                r_skid_data  <= fifo_rd_data;
                r_skid_last  <= w_pop_last;
            end

            if (w_take && r_out_last) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
        end
    end

    assign m_axis_tvalid = r_out_valid;
    assign m_axis_tdata  = r_out_data;
    assign m_axis_tlast  = r_out_last;
    assign pkt_count     = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_fifo_axis_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_axis_reader
// Purpose  : Self-checking bench; three readers (PKT_LEN 4, 8, 1) share one
//            word stream and are checked against an occupancy/stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_axis_reader;

    localparam int c_N = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic tready;

    logic [c_N-1:0][31:0] rd_data;
    logic [c_N-1:0]       rd_empty;
    logic [c_N-1:0]       rd_en;
    logic [c_N-1:0][31:0] tdata;
    logic [c_N-1:0]       tvalid;
    logic [c_N-1:0]       tlast;
    logic [c_N-1:0][31:0] pkt;

    logic [31:0] mem [0:4095];
    int          wr_ptr = 0;
    int          rd_ptr [c_N];
    int          base   [c_N];
    int          taken  [c_N];
    logic [c_N-1:0]       stall;
    logic [c_N-1:0][31:0] stall_data;
    logic [c_N-1:0]       stall_last;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < c_N; g++) begin : g_dut
        localparam int L = (g == 0) ? 4 : ((g == 1) ? 8 : 1);
        assign rd_data[g]  = mem[rd_ptr[g][11:0]];
        assign rd_empty[g] = (rd_ptr[g] == wr_ptr);
        fifo_axis_reader #(.DWIDTH(32), .PKT_LEN(L)) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .fifo_rd_data  (rd_data[g]),
            .fifo_rd_empty (rd_empty[g]),
            .fifo_rd_en    (rd_en[g]),
            .m_axis_tdata  (tdata[g]),
            .m_axis_tvalid (tvalid[g]),
            .m_axis_tready (tready),
            .m_axis_tlast  (tlast[g]),
            .pkt_count     (pkt[g])
        );
    end

    // FIFO pointer and taken-beat bookkeeping, sampled at the DUT edge.
    always @(posedge clk) begin
        for (int k = 0; k < c_N; k++) begin
            if (!rst_n) begin
                base[k]  <= rd_ptr[k];
                taken[k] <= 0;
                stall[k] <= 1'b0;
            end else begin
                if (rd_en[k] && !rd_empty[k]) rd_ptr[k] <= rd_ptr[k] + 1;
                if (tvalid[k] && tready) taken[k] <= taken[k] + 1;
                stall[k]      <= tvalid[k] & ~tready;
                stall_data[k] <= tdata[k];
                stall_last[k] <= tlast[k];
            end
        end
    end

    function automatic int len_of(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 8 : 1);
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %0h, expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Expected outputs from stream position: words buffered = popped - taken.
    task automatic check_cycle();
        int occ;
        int l;
        for (int k = 0; k < c_N; k++) begin
            l = len_of(k);
            if (!rst_n) begin
                chk("rst_tvalid", k, 32'(tvalid[k]), 32'd0);
                chk("rst_tlast", k, 32'(tlast[k]), 32'd0);
                chk("rst_tdata", k, tdata[k], 32'd0);
                chk("rst_rd_en", k, 32'(rd_en[k]), 32'd0);
                chk("rst_pkt", k, pkt[k], 32'd0);
            end else begin
                occ = rd_ptr[k] - base[k] - taken[k];
                chk("occupancy", k, 32'(occ >= 0 && occ <= 2), 32'd1);
                chk("tvalid", k, 32'(tvalid[k]), 32'(occ > 0));
                chk("rd_en", k, 32'(rd_en[k]), 32'(rd_ptr[k] != wr_ptr && occ < 2));
                chk("pkt_count", k, pkt[k], 32'(taken[k] / l));
                if (tvalid[k]) begin
                    chk("tdata", k, tdata[k], mem[(base[k] + taken[k]) % 4096]);
                    chk("tlast", k, 32'(tlast[k]), 32'((taken[k] % l) == l - 1));
                end
                if (stall[k]) begin
                    chk("hold_tvalid", k, 32'(tvalid[k]), 32'd1);
                    chk("hold_tdata", k, tdata[k], stall_data[k]);
                    chk("hold_tlast", k, 32'(tlast[k]), 32'(stall_last[k]));
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic push(input logic [31:0] v);
        mem[wr_ptr % 4096] = v;
        wr_ptr++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input int max_cycles, input bit rnd);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        while (!done && n < max_cycles) begin
            if (rnd) tready = 1'($urandom_range(0, 1));
            tick();
            n++;
            done = 1'b1;
            for (int k = 0; k < c_N; k++)
                if (rd_ptr[k] != wr_ptr || tvalid[k]) done = 1'b0;
        end
        tready = 1'b1;
        chk("drain_in_budget", n, 32'(done), 32'd1);
    endtask

    initial begin
        int n;
        rst_n  = 1'b0;
        tready = 1'b1;

        // Reset with a non-empty FIFO, then release.
        for (int i = 0; i < 3; i++) push(32'hA000_0000 + 32'(i));
        repeat (3) begin
            tick();
            chk("lit_rst_rd_en", 0, 32'(rd_en), 32'd0);
            chk("lit_rst_tvalid", 0, 32'(tvalid), 32'd0);
        end
        rst_n = 1'b1;
        #1;
        chk("lit_release_rd_en", 0, 32'(rd_en), 32'b111);
        chk("lit_release_tvalid", 0, 32'(tvalid), 32'b000);
        tick();
        chk("lit_first_tvalid", 0, 32'(tvalid), 32'b111);
        chk("lit_first_tdata", 0, tdata[0], 32'hA000_0000);
        wait_drain(50, 1'b0);

        // Streaming at full rate: 12 words must leave in 13 cycles.
        do_reset();
        for (int i = 0; i < 12; i++) push(32'(i));
        wait_drain(14, 1'b0);
        chk("lit_stream_pkt", 0, pkt[0], 32'd3);
        chk("lit_stream_pkt", 1, pkt[1], 32'd1);
        chk("lit_stream_pkt", 2, pkt[2], 32'd12);

        // Starvation mid-packet.
        do_reset();
        for (int i = 0; i < 5; i++) push(32'h5000 + 32'(i));
        repeat (25) tick();
        chk("lit_gap_tvalid", 0, 32'(tvalid), 32'b000);
        chk("lit_gap_pkt", 1, pkt[1], 32'd0);
        for (int i = 5; i < 8; i++) push(32'h5000 + 32'(i));
        wait_drain(20, 1'b0);
        chk("lit_starve_pkt", 0, pkt[0], 32'd2);
        chk("lit_starve_pkt", 1, pkt[1], 32'd1);
        chk("lit_starve_pkt", 2, pkt[2], 32'd8);

        // Five words: PKT_LEN=1 frames every beat.
        do_reset();
        for (int i = 0; i < 5; i++) push(32'h1100 + 32'(i));
        wait_drain(20, 1'b0);
        chk("lit_len1_pkt", 2, pkt[2], 32'd5);
        chk("lit_len1_pkt", 0, pkt[0], 32'd1);

        // Random 50% backpressure over 1000 words.
        do_reset();
        for (int i = 0; i < 1000; i++) push($urandom);
        wait_drain(8000, 1'b1);
        chk("lit_bp_pkt", 0, pkt[0], 32'd250);
        chk("lit_bp_pkt", 1, pkt[1], 32'd125);
        chk("lit_bp_pkt", 2, pkt[2], 32'd1000);

        // Reset mid-packet with both registers occupied.
        do_reset();
        for (int i = 0; i < 4; i++) push(32'd100 + 32'(i));
        n = 0;
        while (taken[0] < 2 && n < 20) begin
            tick();
            n++;
        end
        chk("lit_mid_two_beats", 0, 32'(taken[0]), 32'd2);
        tready = 1'b0;
        repeat (3) tick();
        chk("lit_mid_stalled_tvalid", 0, 32'(tvalid), 32'b111);
        chk("lit_mid_stalled_tdata", 0, tdata[0], 32'd102);
        rst_n = 1'b0;
        #1;
        chk("lit_mid_rst_tvalid", 0, 32'(tvalid), 32'b000);
        chk("lit_mid_rst_tdata", 0, tdata[0], 32'd0);
        tick();
        tick();
        rst_n  = 1'b1;
        tready = 1'b1;
        for (int i = 0; i < 4; i++) push(32'd200 + 32'(i));
        tick();
        chk("lit_mid_new_tdata", 0, tdata[0], 32'd200);
        wait_drain(20, 1'b0);
        chk("lit_mid_pkt", 0, pkt[0], 32'd1);
        chk("lit_mid_pkt", 1, pkt[1], 32'd0);
        chk("lit_mid_pkt", 2, pkt[2], 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
